// File: rtl/uart_tx_shift.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_shift
//  Purpose  : UART transmit path with a one-byte holding register, a shift
//             register and a five-state bit sequencer. Supports 7 or 8 data
//             bits and optional odd/even parity. The bit rate is set entirely
//             by an external xmit_pulse strobe.
//  Revision : 1.0  initial release
//
//  Ports
//    clk         in   1  system clock, rising edge
//    reset_n     in   1  asynchronous active-low reset
//    xmit_pulse  in   1  one-clk strobe per bit time
//    tx_data     in   8  byte to send
//    tx_load     in   1  write strobe for tx_data (ignored when not ready)
//    bit8        in   1  1 = 8 data bits, 0 = 7 data bits
//    parity_en   in   1  1 = append parity bit
//    odd_n_even  in   1  1 = odd parity, 0 = even parity
//    tx          out  1  serial line, registered, idle high
//    tx_ready    out  1  holding register empty
//    tx_busy     out  1  frame in progress or holding register full
// ============================================================================
module uart_tx_shift (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       xmit_pulse,
   input  logic [7:0] tx_data,
   input  logic       tx_load,
   input  logic       bit8,
   input  logic       parity_en,
   input  logic       odd_n_even,
   output logic       tx,
   output logic       tx_ready,
   output logic       tx_busy
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic       tx_q, tx_d;
   logic       ready_q, ready_d;
   logic [7:0] hold_q, hold_d;
   logic [7:0] shift_q, shift_d;
   logic [3:0] idx_q, idx_d;
   logic       bit8_q, bit8_d;
   logic       par_en_q, par_en_d;
   logic       odd_q, odd_d;

   logic [3:0] n_bits;
   logic       parity_bit;
   logic       xfer;

   assign n_bits = bit8_q ? 4'd8 : 4'd7;

   // In 7-bit mode bit 7 of the shift register is not transmitted, so it is
   // masked out of the parity sum.
   assign parity_bit = (^(shift_q & {bit8_q, 7'h7F})) ^ odd_q;

   always_comb begin
      state_d  = state_q;
      tx_d     = tx_q;
      ready_d  = ready_q;
      hold_d   = hold_q;
      shift_d  = shift_q;
      idx_d    = idx_q;
      bit8_d   = bit8_q;
      par_en_d = par_en_q;
      odd_d    = odd_q;
      xfer     = 1'b0;

      if (xmit_pulse) begin
         case (state_q)
            IDLE: begin
               tx_d = 1'b1;
               if (!ready_q) begin
                  xfer = 1'b1;
               end
            end
            START: begin
               tx_d    = shift_q[0];
               idx_d   = 4'd1;
               state_d = DATA;
            end
            DATA: begin
               if (idx_q < n_bits) begin
                  tx_d  = shift_q[idx_q[2:0]];
                  idx_d = idx_q + 4'd1;
               end else if (par_en_q) begin
                  tx_d    = parity_bit;
                  state_d = PARITY;
               end else begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end
            end
            PARITY: begin
               tx_d    = 1'b1;
               state_d = STOP;
            end
            STOP: begin
               // A waiting byte starts immediately: the start bit directly
               // follows this stop bit with no idle bit in between.
               if (!ready_q) begin
                  xfer = 1'b1;
               end else begin
                  tx_d    = 1'b1;
                  state_d = IDLE;
               end
            end
            default: begin
               tx_d    = 1'b1;
               state_d = IDLE;
            end
         endcase
      end

      // Frame options are captured with the byte so mid-frame changes on the
      // inputs only affect the next frame.
      if (xfer) begin
         shift_d  = hold_q;
         bit8_d   = bit8;
         par_en_d = parity_en;
         odd_d    = odd_n_even;
         ready_d  = 1'b1;
         tx_d     = 1'b0;
         idx_d    = 4'd0;
         state_d  = START;
      end

      // xfer only fires with ready_q low, so a load in the transfer cycle is
      // never accepted.
      if (tx_load && ready_q) begin
         hold_d  = tx_data;
         ready_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         tx_q     <= 1'b1;
         ready_q  <= 1'b1;
         hold_q   <= 8'h00;
         shift_q  <= 8'h00;
         idx_q    <= 4'd0;
         bit8_q   <= 1'b0;
         par_en_q <= 1'b0;
         odd_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         tx_q     <= tx_d;
         ready_q  <= ready_d;
         hold_q   <= hold_d;
         shift_q  <= shift_d;
         idx_q    <= idx_d;
         bit8_q   <= bit8_d;
         par_en_q <= par_en_d;
         odd_q    <= odd_d;
      end
   end

   assign tx       = tx_q;
   assign tx_ready = ready_q;
   assign tx_busy  = (state_q != IDLE) || !ready_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_shift.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_shift
//  Purpose  : Self-checking bench for uart_tx_shift. A frame-level model
//             predicts which bytes are sent and with what framing; a monitor
//             decodes the serial line and compares against the queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_shift;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       xmit_pulse = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_load = 1'b0;
   logic       bit8 = 1'b1;
   logic       parity_en = 1'b0;
   logic       odd_n_even = 1'b0;
   logic       tx;
   logic       tx_ready;
   logic       tx_busy;

   uart_tx_shift dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .xmit_pulse (xmit_pulse),
      .tx_data    (tx_data),
      .tx_load    (tx_load),
      .bit8       (bit8),
      .parity_en  (parity_en),
      .odd_n_even (odd_n_even),
      .tx         (tx),
      .tx_ready   (tx_ready),
      .tx_busy    (tx_busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] data;
      int         n;
      bit         pe;
      logic       par;
   } frame_t;

   frame_t exp_q[$];

   // Frame-level model: bit times left in the current frame and holding state
   bit         m_hold_full = 1'b0;
   logic [7:0] m_hold = 8'h00;
   int         m_rem = 0;
   int         pcnt = 0;
   int         period = 1;
   bit         mon_busy = 1'b0;

   task automatic chk(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // One clock with the given strobes; updates the model and checks flags.
   task automatic cycle(input bit pulse, input bit load, input logic [7:0] data);
      logic   prev_tx;
      bit     xfer;
      bit     acc;
      frame_t f;
      @(negedge clk);
      xmit_pulse = pulse;
      tx_load    = load;
      tx_data    = data;
      prev_tx    = tx;
      xfer = pulse && (m_rem <= 1) && m_hold_full;
      if (xfer) begin
         f.n    = bit8 ? 8 : 7;
         f.pe   = parity_en;
         f.data = bit8 ? m_hold : {1'b0, m_hold[6:0]};
         f.par  = odd_n_even;
         for (int i = 0; i < f.n; i++) f.par = f.par ^ f.data[i];
         exp_q.push_back(f);
         m_rem = 2 + f.n + (f.pe ? 1 : 0);
      end else if (pulse && m_rem > 0) begin
         m_rem--;
      end
      acc = load && !m_hold_full;
      if (acc) m_hold = data;
      m_hold_full = (m_hold_full && !xfer) || acc;
      @(posedge clk);
      #1;
      chk("tx_ready", tx_ready, !m_hold_full);
      chk("tx_busy", tx_busy, (m_rem > 0) || m_hold_full);
      if (!pulse) chk("tx_stable", tx, prev_tx);
      xmit_pulse = 1'b0;
      tx_load    = 1'b0;
   endtask

   task automatic tick(input bit load, input logic [7:0] data);
      bit p;
      pcnt++;
      p = (period > 0) && ((pcnt % period) == 0);
      cycle(p, load, data);
   endtask

   task automatic idle_ticks(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("rst_tx", tx, 1'b1);
      chk("rst_ready", tx_ready, 1'b1);
      chk("rst_busy", tx_busy, 1'b0);
      m_rem = 0;
      m_hold_full = 1'b0;
      exp_q.delete();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Monitor: decodes frames from the serial line at each bit strobe.
   initial begin : monitor
      frame_t     cur;
      logic [7:0] got;
      logic       got_par;
      int         k;
      got = 8'h00;
      got_par = 1'b0;
      k = 0;
      forever begin
         @(posedge clk);
         if (!reset_n) begin
            mon_busy = 1'b0;
            continue;
         end
         if (!xmit_pulse) continue;
         #1;
         if (!reset_n) begin
            mon_busy = 1'b0;
            continue;
         end
         if (!mon_busy) begin
            if (tx === 1'b0) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_start: got start bit expected idle at %0t", $time);
               end else begin
                  cur = exp_q.pop_front();
                  mon_busy = 1'b1;
                  k = 0;
                  got = 8'h00;
               end
            end
         end else begin
            if (k < cur.n) begin
               got[k] = tx;
            end else if (cur.pe && k == cur.n) begin
               got_par = tx;
            end else begin
               chk8("frame_data", got, cur.data);
               if (cur.pe) chk("frame_parity", got_par, cur.par);
               chk("frame_stop", tx, 1'b1);
               mon_busy = 1'b0;
            end
            k++;
         end
      end
   end

   initial begin : stimulus
      // Reset state
      repeat (2) @(negedge clk);
      chk("init_tx", tx, 1'b1);
      chk("init_ready", tx_ready, 1'b1);
      chk("init_busy", tx_busy, 1'b0);
      reset_n = 1'b1;
      idle_ticks(4);

      // 8N1, 0xA5, 16 clocks per bit
      period = 16; pcnt = 0;
      bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
      tick(1'b1, 8'hA5);
      idle_ticks(16 * 12);

      // 7E1 and 7O1 with 0x41
      period = 4; pcnt = 0;
      bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b0;
      tick(1'b1, 8'h41);
      idle_ticks(4 * 12);
      odd_n_even = 1'b1;
      tick(1'b1, 8'h41);
      idle_ticks(4 * 12);

      // Back-to-back: reload on the first ready cycle
      period = 3; pcnt = 0;
      bit8 = 1'b1; parity_en = 1'b0;
      tick(1'b1, 8'h55);
      for (int i = 0; i < 20 && m_hold_full; i++) tick(1'b0, 8'h00);
      tick(1'b1, 8'h0F);
      idle_ticks(3 * 24);

      // Overrun: three loads with no strobes, only the first survives
      period = 0;
      tick(1'b1, 8'h11);
      tick(1'b1, 8'h22);
      tick(1'b1, 8'h33);
      period = 2; pcnt = 0;
      idle_ticks(2 * 12);

      // Reset mid-frame with a byte held
      period = 2; pcnt = 0;
      tick(1'b1, 8'h3C);
      idle_ticks(9);
      tick(1'b1, 8'hC3);
      do_reset();
      idle_ticks(40);

      // Parity enable toggled mid-frame
      period = 2; pcnt = 0;
      bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
      tick(1'b1, 8'h96);
      idle_ticks(8);
      parity_en = 1'b1;
      tick(1'b1, 8'h69);
      idle_ticks(2 * 26);

      // Randomised traffic, strobe density and configuration
      for (int i = 0; i < 4000; i++) begin
         int k;
         if ((i % 250) == 0) k = 1 + ($urandom % 3);
         if (($urandom % 60) == 0) begin
            bit8       = $urandom % 2;
            parity_en  = $urandom % 2;
            odd_n_even = $urandom % 2;
         end
         cycle(($urandom % k) == 0, ($urandom % 4) == 0, 8'($urandom));
      end

      // Drain
      for (int i = 0; i < 500 && (m_rem > 0 || m_hold_full); i++) cycle(1'b1, 1'b0, 8'h00);
      repeat (3) cycle(1'b1, 1'b0, 8'h00);
      checks++;
      if (exp_q.size() != 0 || mon_busy) begin
         errors++;
         $display("FAIL drain: got %0d frames pending expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_shift.md
UART_TX_SHIFT -- requirements
Module: uart_tx_shift

Interface
REQ-001 The block SHALL have no parameters; all frame options SHALL be run-time inputs.
REQ-002 clk  input  1  system clock; all logic SHALL be rising-edge clk.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 xmit_pulse  input  1  one-clk strobe per bit time, from the baud clock generator.
REQ-005 tx_data  input  8  byte to send.
REQ-006 tx_load  input  1  one-clk write strobe for tx_data.
REQ-007 bit8  input  1  1 = 8 data bits; 0 = 7 data bits (tx_data[6:0]).
REQ-008 parity_en  input  1  1 = append parity bit.
REQ-009 odd_n_even  input  1  1 = odd parity; 0 = even parity.
REQ-010 tx  output  1  serial line, registered, idle high.
REQ-011 tx_ready  output  1  holding register empty; a tx_load is accepted.
REQ-012 tx_busy  output  1  frame in progress or holding register full.

Function
REQ-013 Holding register: tx_load with tx_ready=1 SHALL capture tx_data and clear tx_ready on the next edge.
REQ-014 tx_load with tx_ready=0 SHALL be ignored; holding contents unchanged, no error flag.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 FSM transitions and tx updates SHALL occur only on clk edges where xmit_pulse=1.
REQ-017 IDLE: tx=1; with holding full at xmit_pulse -> copy holding to shift register, latch bit8/parity_en/odd_n_even, set tx_ready=1, tx<=0, go START.
REQ-018 START: at xmit_pulse, tx<=data bit 0 (LSB first), bit index<=1, go DATA.
REQ-019 DATA: at xmit_pulse, if index < N (N=8 or 7 per latched bit8), tx<=bit[index] and index increments.
REQ-020 DATA, index = N: go PARITY with tx<=parity if latched parity_en=1, else go STOP with tx<=1.
REQ-021 Parity bit SHALL be the XOR of the N transmitted data bits, inverted when latched odd_n_even=1.
REQ-022 PARITY: at xmit_pulse, tx<=1, go STOP.
REQ-023 STOP, holding full at xmit_pulse: start next frame exactly as in REQ-017, with no idle bit between frames.
REQ-024 STOP, holding empty at xmit_pulse: go IDLE, tx stays 1.
REQ-025 Frame length SHALL be 1+N+P+1 bit times (P=1 if parity enabled, else 0).
REQ-026 Config input changes mid-frame SHALL NOT affect the current frame.
REQ-027 tx_load in the same cycle as the holding-to-shift transfer SHALL be ignored; tx_ready was 0 that cycle.
REQ-028 tx_load on the cycle after the transfer (tx_ready=1) SHALL be accepted.
REQ-029 tx_busy SHALL equal (state != IDLE) OR (tx_ready=0), combinationally from registers.
REQ-030 xmit_pulse held high for consecutive cycles SHALL advance one bit per cycle (no internal rate limiting).

Reset
REQ-031 reset_n=0 SHALL asynchronously set: tx=1, tx_ready=1, tx_busy=0, state IDLE, holding/shift/index/latched config = 0.
REQ-032 Reset mid-frame SHALL abort the frame: tx=1 immediately; the pending holding byte is discarded.
REQ-033 After reset release, no frame SHALL start until a new tx_load is accepted.

Verification
REQ-034 8N1: bit8=1, parity_en=0, xmit_pulse every 16 clk, tx_load 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, 16 clk per bit; tx_busy low after final stop.
REQ-035 7E1 and 7O1: bit8=0, parity_en=1, tx_data 0x41 -> data bits 1,0,0,0,0,0,1 then parity 0 (even) / 1 (odd), then stop 1; 10 bit times total.
REQ-036 Back-to-back: load 0x55, reload on first cycle tx_ready=1 with 0x0F -> second start bit immediately follows first stop bit, no extra idle bit.
REQ-037 Overrun: three tx_load pulses 0x11, 0x22, 0x33 in consecutive cycles while idle -> only 0x11 transmitted; 0x22 and 0x33 dropped; tx_ready=0 until 0x11 moves to shift register.
REQ-038 Reset mid-frame: assert reset_n during data bit 3 with a byte held -> tx=1, tx_ready=1 same cycle; no frame after release without new tx_load.
REQ-039 Config change mid-frame: toggle parity_en 0->1 during DATA -> current frame has no parity bit; next frame includes parity.
